// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit that owns the HI/LO result registers.
//   mult/multu/div/divu run for a fixed, parameterised number of Busy cycles and then
//   commit to HI/LO. mthi/mtlo write HI/LO directly and do not raise Busy.
//   Optional feature macro: MDU_MADD_EN adds madd/maddu, which accumulate the product
//   into {HI,LO}. When the macro is undefined, ops 7/8 are no-ops.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset, clears all state
//   Start - qualifies MDUOp for one cycle
//   MDUOp - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu
//   SrcA  - rs operand (dividend / multiplicand / mthi-mtlo data)
//   SrcB  - rt operand (divisor / multiplier)
//   Busy  - high while an operation is in flight
//   HI/LO - result registers
module mdu_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMadd  = 4'd7,
        OpMaddu = 4'd8
    } mdu_op_e;

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0]  MultLoad = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0]  DivLoad  = CntW'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] MinNeg   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CntW-1:0]  cnt_q;
    mdu_op_e          op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    // Datapath on latched operands
    logic [2*WIDTH-1:0] a_sext, b_sext, a_zext, b_zext;
    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   quo_s, rem_s, quo_u, rem_u;
    logic               div_zero, div_ovf;
    logic [2*WIDTH-1:0] result;
    logic               commit_ok;
    logic               op_valid;

    always_comb begin
        a_sext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_sext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        a_zext = {{WIDTH{1'b0}}, a_q};
        b_zext = {{WIDTH{1'b0}}, b_q};
        // Low 2*WIDTH bits of the extended product equal the exact signed/unsigned product.
        prod_s = a_sext * b_sext;
        prod_u = a_zext * b_zext;

        div_zero = (b_q == '0);
        div_ovf  = (a_q == MinNeg) && (b_q == '1);
        // Divide by a harmless value in the special cases so the divider never sees 0 or
        // the overflowing most-negative / -1 pair; those results are overridden below.
        b_safe = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_q;
        quo_s  = $signed(a_q) / $signed(b_safe);
        rem_s  = $signed(a_q) % $signed(b_safe);
        quo_u  = a_q / b_safe;
        rem_u  = a_q % b_safe;

        result    = {hi_q, lo_q};
        commit_ok = 1'b1;
        case (op_q)
            OpMult:  result = prod_s;
            OpMultu: result = prod_u;
            OpDiv: begin
                if (div_zero)     commit_ok = 1'b0;
                else if (div_ovf) result    = {{WIDTH{1'b0}}, MinNeg};
                else              result    = {rem_s, quo_s};
            end
            OpDivu: begin
                if (div_zero) commit_ok = 1'b0;
                else          result    = {rem_u, quo_u};
            end
`ifdef MDU_MADD_EN
            OpMadd:  result = {hi_q, lo_q} + prod_s;
            OpMaddu: result = {hi_q, lo_q} + prod_u;
`endif
            default: commit_ok = 1'b0;
        endcase
    end

    always_comb begin
        op_valid = 1'b0;
        case (mdu_op_e'(MDUOp))
            OpMult, OpMultu, OpDiv, OpDivu, OpMthi, OpMtlo: op_valid = 1'b1;
`ifdef MDU_MADD_EN
            OpMadd, OpMaddu: op_valid = 1'b1;
`endif
            default: op_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            op_q  <= OpNone;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (cnt_q != '0) begin
            // In flight: any Start is ignored; commit on the last counted edge.
            cnt_q <= cnt_q - CntW'(1);
            if (cnt_q == CntW'(1) && commit_ok) begin
                hi_q <= result[2*WIDTH-1:WIDTH];
                lo_q <= result[WIDTH-1:0];
            end
        end else if (Start && op_valid) begin
            case (mdu_op_e'(MDUOp))
                OpMthi: hi_q <= SrcA;
                OpMtlo: lo_q <= SrcA;
                default: begin
                    a_q   <= SrcA;
                    b_q   <= SrcB;
                    op_q  <= mdu_op_e'(MDUOp);
                    cnt_q <= (MDUOp == OpDiv || MDUOp == OpDivu) ? DivLoad : MultLoad;
                end
            endcase
        end
    end

    assign Busy = (cnt_q != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: self-checking bench for mdu_unit. Uses a default-parameter instance plus a
// WIDTH=16 / single-cycle instance. Expected values come from a 64-bit arithmetic model.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  MDUOp = 4'd0;
    logic [31:0] SrcA = '0, SrcB = '0;
    logic        Busy;
    logic [31:0] HI, LO;

    logic        s_start = 1'b0;
    logic [3:0]  s_op = 4'd0;
    logic [15:0] s_a = '0, s_b = '0;
    logic        s_busy;
    logic [15:0] s_hi, s_lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] hi_m, lo_m;

    always #5 clk = ~clk;

    mdu_unit dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    mdu_unit #(
        .WIDTH       (16),
        .MULT_CYCLES (1),
        .DIV_CYCLES  (1)
    ) dut_small (
        .clk   (clk),
        .reset (reset),
        .Start (s_start),
        .MDUOp (s_op),
        .SrcA  (s_a),
        .SrcB  (s_b),
        .Busy  (s_busy),
        .HI    (s_hi),
        .LO    (s_lo)
    );

    // Reference model: applies one accepted op to hi_m/lo_m, returns expected Busy cycles.
    function automatic int model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin p = 64'(sa * sb); {hi_m, lo_m} = p; return 5; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = p; return 5; end
            4'd3: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa - q * sb;
                    lo_m = q[31:0];
                    hi_m = r[31:0];
                end
                return 10;
            end
            4'd4: begin
                if (b != 0) begin
                    lo_m = a / b;
                    hi_m = a - (a / b) * b;
                end
                return 10;
            end
            4'd5: begin hi_m = a; return 0; end
            4'd6: begin lo_m = a; return 0; end
`ifdef MDU_MADD_EN
            4'd7: begin acc = {hi_m, lo_m} + 64'(sa * sb); {hi_m, lo_m} = acc; return 5; end
            4'd8: begin
                acc = {hi_m, lo_m} + {32'd0, a} * {32'd0, b};
                {hi_m, lo_m} = acc;
                return 5;
            end
`endif
            default: return 0;
        endcase
    endfunction

    // Drives one op at the current negedge; returns on the first negedge with Busy low.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_n);
        Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        busy_n = 0;
        while (Busy && busy_n < 200) begin
            busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++; if (HI !== 32'd0) $display("FAIL reset_hi: got %h want 0", HI); else pass_cnt++;
        total_cnt++; if (LO !== 32'd0) $display("FAIL reset_lo: got %h want 0", LO); else pass_cnt++;
        total_cnt++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else pass_cnt++;
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        int n;
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, n);
        void'(model(4'd1, 32'hFFFF_FFFE, 32'd3));
        total_cnt++; if (n !== 5) $display("FAIL mult_busy: got %0d want 5", n); else pass_cnt++;
        total_cnt++; if (HI !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", HI); else pass_cnt++;
        total_cnt++; if (LO !== 32'hFFFF_FFFA) $display("FAIL mult_lo: got %h want fffffffa", LO); else pass_cnt++;

        issue(4'd2, 32'hFFFF_FFFE, 32'd3, n);
        void'(model(4'd2, 32'hFFFF_FFFE, 32'd3));
        total_cnt++; if (HI !== 32'h2) $display("FAIL multu_hi: got %h want 00000002", HI); else pass_cnt++;
        total_cnt++; if (LO !== 32'hFFFF_FFFA) $display("FAIL multu_lo: got %h want fffffffa", LO); else pass_cnt++;

        issue(4'd3, -32'sd7, 32'd2, n);
        void'(model(4'd3, -32'sd7, 32'd2));
        total_cnt++; if (n !== 10) $display("FAIL div_busy: got %0d want 10", n); else pass_cnt++;
        total_cnt++; if (LO !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h want fffffffd", LO); else pass_cnt++;
        total_cnt++; if (HI !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h want ffffffff", HI); else pass_cnt++;

        issue(4'd4, 32'd7, 32'd2, n);
        void'(model(4'd4, 32'd7, 32'd2));
        total_cnt++; if (LO !== 32'd3) $display("FAIL divu_lo: got %h want 3", LO); else pass_cnt++;
        total_cnt++; if (HI !== 32'd1) $display("FAIL divu_hi: got %h want 1", HI); else pass_cnt++;

        issue(4'd3, 32'd5, 32'd0, n);
        void'(model(4'd3, 32'd5, 32'd0));
        total_cnt++; if (n !== 10) $display("FAIL div0_busy: got %0d want 10", n); else pass_cnt++;
        total_cnt++; if (HI !== 32'd1 || LO !== 32'd3)
            $display("FAIL div0_keep: got %h/%h want 00000001/00000003", HI, LO); else pass_cnt++;

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        void'(model(4'd3, 32'h8000_0000, 32'hFFFF_FFFF));
        total_cnt++; if (HI !== 32'd0 || LO !== 32'h8000_0000)
            $display("FAIL div_ovf: got %h/%h want 00000000/80000000", HI, LO); else pass_cnt++;
    endtask

    task automatic test_start_while_busy;
        int n;
        Start = 1'b1; MDUOp = 4'd1; SrcA = 32'd7; SrcB = 32'd6;
        @(negedge clk);
        total_cnt++; if (Busy !== 1'b1) $display("FAIL busy_raise: got %b want 1", Busy); else pass_cnt++;
        SrcA = 32'd100; SrcB = 32'd100;  // second Start held while busy
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        n = 1;
        while (Busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        void'(model(4'd1, 32'd7, 32'd6));
        total_cnt++; if (n !== 5) $display("FAIL ignore_busy_len: got %0d want 5", n); else pass_cnt++;
        total_cnt++; if (HI !== hi_m || LO !== lo_m)
            $display("FAIL ignore_result: got %h/%h want %h/%h", HI, LO, hi_m, lo_m); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (Busy !== 1'b0) $display("FAIL ignore_no_rerun: got %b want 0", Busy); else pass_cnt++;
    endtask

    task automatic test_mthi;
        int n;
        issue(4'd5, 32'h1234, 32'd0, n);
        void'(model(4'd5, 32'h1234, 32'd0));
        total_cnt++; if (n !== 0) $display("FAIL mthi_busy: got %0d want 0", n); else pass_cnt++;
        total_cnt++; if (HI !== 32'h1234) $display("FAIL mthi_hi: got %h want 00001234", HI); else pass_cnt++;
        issue(4'd6, 32'hCAFE_0001, 32'd0, n);
        void'(model(4'd6, 32'hCAFE_0001, 32'd0));
        total_cnt++; if (LO !== 32'hCAFE_0001 || HI !== 32'h1234)
            $display("FAIL mtlo: got %h/%h want 00001234/cafe0001", HI, LO); else pass_cnt++;
    endtask

    task automatic test_madd;
        int n;
        issue(4'd5, 32'd0, 32'd0, n);
        void'(model(4'd5, 32'd0, 32'd0));
        issue(4'd6, 32'hFFFF_FFFF, 32'd0, n);
        void'(model(4'd6, 32'hFFFF_FFFF, 32'd0));
        issue(4'd8, 32'd1, 32'd1, n);
`ifdef MDU_MADD_EN
        total_cnt++; if (n !== 5) $display("FAIL maddu_busy: got %0d want 5", n); else pass_cnt++;
        total_cnt++; if (HI !== 32'd1 || LO !== 32'd0)
            $display("FAIL maddu: got %h/%h want 00000001/00000000", HI, LO); else pass_cnt++;
`else
        total_cnt++; if (n !== 0) $display("FAIL maddu_busy: got %0d want 0", n); else pass_cnt++;
        total_cnt++; if (HI !== 32'd0 || LO !== 32'hFFFF_FFFF)
            $display("FAIL maddu_noop: got %h/%h want 00000000/ffffffff", HI, LO); else pass_cnt++;
`endif
        void'(model(4'd8, 32'd1, 32'd1));
    endtask

    // Back-to-back random ops; each issue starts on the first Busy-low cycle.
    task automatic test_random;
        int n, exp_n;
        logic [3:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 10));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            issue(op, a, b, n);
            exp_n = model(op, a, b);
            total_cnt++; if (n !== exp_n)
                $display("FAIL rand_busy[%0d] op%0d: got %0d want %0d", i, op, n, exp_n); else pass_cnt++;
            total_cnt++; if (HI !== hi_m)
                $display("FAIL rand_hi[%0d] op%0d a=%h b=%h: got %h want %h", i, op, a, b, HI, hi_m);
            else pass_cnt++;
            total_cnt++; if (LO !== lo_m)
                $display("FAIL rand_lo[%0d] op%0d a=%h b=%h: got %h want %h", i, op, a, b, LO, lo_m);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_div;
        int n;
        issue(4'd6, 32'h55, 32'd0, n);
        Start = 1'b1; MDUOp = 4'd3; SrcA = 32'd100; SrcB = 32'd7;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total_cnt++; if (Busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", Busy); else pass_cnt++;
        total_cnt++; if (HI !== 32'd0 || LO !== 32'd0)
            $display("FAIL abort_clear: got %h/%h want 0/0", HI, LO); else pass_cnt++;
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        repeat (12) @(negedge clk);
        total_cnt++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
            $display("FAIL abort_no_commit: got busy=%b %h/%h want 0 0/0", Busy, HI, LO); else pass_cnt++;
    endtask

    task automatic test_small_width;
        int n;
        s_start = 1'b1; s_op = 4'd1; s_a = 16'h8000; s_b = 16'h8000;
        @(negedge clk);
        s_start = 1'b0; s_op = 4'd0;
        n = 0;
        while (s_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        total_cnt++; if (n !== 1) $display("FAIL w16_busy: got %0d want 1", n); else pass_cnt++;
        total_cnt++; if (s_hi !== 16'h4000 || s_lo !== 16'h0000)
            $display("FAIL w16_mult: got %h/%h want 4000/0000", s_hi, s_lo); else pass_cnt++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_start_while_busy();
        test_mthi();
        test_madd();
        test_random();
        test_reset_mid_div();
        test_small_width();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
